mesi_bus_arbiter: RTL and testbench

- Arbiter for the shared coherence bus of the multi-core MESI cache system. Drives the per-requester proc grants, the snoop grants and the memory snoop grant.
- Proc channel: round-robin over 2*CORES requesters (DL and IL per core) for ownership of the common bus.
- Snoop channel: arbitrates cache snoop responders plus lower-level memory, and is active only during a proc tenure.
- All grants are registered and one-hot per channel.

---
 rtl/mesi_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mesi_bus_arbiter.sv
// Shared coherence-bus arbiter: round-robin proc ownership plus a snoop channel live only during a tenure.
// Optional macro ARB_TIMEOUT_EN bounds each tenure to TIMEOUT_CYCLES and raises a sticky Arb_timeout.
module mesi_bus_arbiter #(
  parameter int CORES          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*CORES-1:0]           Com_Bus_Req_proc,
  output logic [2*CORES-1:0]           Com_Bus_Gnt_proc,
  input  logic [CORES-1:0]             Com_Bus_Req_snoop,
  output logic [CORES-1:0]             Com_Bus_Gnt_snoop,
  input  logic                         Mem_snoop_req,
  output logic                         Mem_snoop_gnt,
  output logic [$clog2(2*CORES)-1:0]   Bus_owner,
  output logic                         Bus_busy,
  output logic                         Arb_timeout
);

  localparam int NP = 2 * CORES;
  localparam int OW = $clog2(NP);
  localparam int SW = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [OW-1:0]    rr_ptr;
  logic [SW-1:0]    snoop_ptr;
  logic             proc_found;
  logic [OW-1:0]    proc_pick;
  logic [OW-1:0]    proc_next;
  logic             snoop_found;
  logic [SW-1:0]    snoop_pick;
  logic [SW-1:0]    snoop_next;
  logic [CORES-1:0] snoop_elig;
  logic             owner_req;
  logic             snoop_hold;
  logic             timeout_hit;

  function automatic logic [OW-1:0] proc_wrap(input logic [OW-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NP) t = t - NP;
    return OW'(t);
  endfunction

  function automatic logic [SW-1:0] snoop_wrap(input logic [SW-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= CORES) t = t - CORES;
    return SW'(t);
  endfunction

  always_comb begin
    proc_found = 1'b0;
    proc_pick  = '0;
    for (int k = 0; k < NP; k++) begin
      if (!proc_found && Com_Bus_Req_proc[proc_wrap(rr_ptr, k)]) begin
        proc_found = 1'b1;
        proc_pick  = proc_wrap(rr_ptr, k);
      end
    end
    proc_next = proc_wrap(proc_pick, 1);
  end

  // The owning core never answers its own snoop, so its bit is masked out.
  always_comb begin
    snoop_elig  = '0;
    snoop_found = 1'b0;
    snoop_pick  = '0;
    for (int c = 0; c < CORES; c++)
      snoop_elig[c] = Com_Bus_Req_snoop[c] && ((int'(Bus_owner) >> 1) != c);
    for (int k = 0; k < CORES; k++) begin
      if (!snoop_found && snoop_elig[snoop_wrap(snoop_ptr, k)]) begin
        snoop_found = 1'b1;
        snoop_pick  = snoop_wrap(snoop_ptr, k);
      end
    end
    snoop_next = snoop_wrap(snoop_pick, 1);
  end

  assign owner_req  = Com_Bus_Req_proc[Bus_owner];
  assign snoop_hold = (|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop)) || (Mem_snoop_gnt && Mem_snoop_req);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tenure_cnt;

  assign timeout_hit = (state == GRANT) && (tenure_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenure_cnt  <= '0;
      Arb_timeout <= 1'b0;
    end else if (state != GRANT) begin
      tenure_cnt <= '0;
    end else begin
      tenure_cnt <= tenure_cnt + 1'b1;
      if (timeout_hit && owner_req) Arb_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Arb_timeout = 1'b0;
`endif

  // RELEASE is the single dead cycle; it already arbitrates so the next tenure starts one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      snoop_ptr         <= '0;
      Com_Bus_Gnt_proc  <= '0;
      Com_Bus_Gnt_snoop <= '0;
      Mem_snoop_gnt     <= 1'b0;
      Bus_owner         <= '0;
      Bus_busy          <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          Com_Bus_Gnt_snoop <= '0;
          Mem_snoop_gnt     <= 1'b0;
          if (proc_found) begin
            Com_Bus_Gnt_proc <= NP'(1) << proc_pick;
            Bus_owner        <= proc_pick;
            Bus_busy         <= 1'b1;
            rr_ptr           <= proc_next;
            state            <= GRANT;
          end else begin
            Com_Bus_Gnt_proc <= '0;
            Bus_busy         <= 1'b0;
            state            <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req || timeout_hit) begin
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
            Bus_busy          <= 1'b0;
            state             <= RELEASE;
          end else if (!snoop_hold) begin
            if (snoop_found) begin
              Com_Bus_Gnt_snoop <= CORES'(1) << snoop_pick;
              Mem_snoop_gnt     <= 1'b0;
              snoop_ptr         <= snoop_next;
            end else begin
              Com_Bus_Gnt_snoop <= '0;
              Mem_snoop_gnt     <= Mem_snoop_req;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter (CORES=4): vector table plus round-robin, async reset and timeout sequences.
module tb_mesi_bus_arbiter;

  localparam int CORES = 4;

  typedef struct {
    logic [7:0] req_proc;
    logic [3:0] req_snoop;
    logic       mem_req;
    logic [7:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       mem_gnt;
    logic [2:0] owner;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_proc;
  logic [7:0] gnt_proc;
  logic [3:0] req_snoop;
  logic [3:0] gnt_snoop;
  logic       mem_req;
  logic       mem_gnt;
  logic [2:0] owner;
  logic       busy;
  logic       arb_timeout;

  int total = 0;
  int bad   = 0;
  vec_t vecs[18];

  mesi_bus_arbiter #(.CORES(CORES), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Req_snoop (req_snoop),
    .Com_Bus_Gnt_snoop (gnt_snoop),
    .Mem_snoop_req     (mem_req),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_owner         (owner),
    .Bus_busy          (busy),
    .Arb_timeout       (arb_timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] rp, input logic [3:0] rs, input logic mr,
                              input logic [7:0] gp, input logic [3:0] gs, input logic mg,
                              input logic [2:0] ow, input logic bz);
    vec_t v;
    v.req_proc = rp; v.req_snoop = rs; v.mem_req = mr;
    v.gnt_proc = gp; v.gnt_snoop = gs; v.mem_gnt = mg; v.owner = ow; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req_proc  = v.req_proc;
    req_snoop = v.req_snoop;
    mem_req   = v.mem_req;
    step();
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, " gnt_proc"}, 32'(gnt_proc), 32'(v.gnt_proc));
    chk({tag, " gnt_snoop"}, 32'(gnt_snoop), 32'(v.gnt_snoop));
    chk({tag, " mem_gnt"}, 32'(mem_gnt), 32'(v.mem_gnt));
    chk({tag, " busy"}, 32'(busy), 32'(v.busy));
    if (v.busy) chk({tag, " owner"}, 32'(owner), 32'(v.owner));
    chk({tag, " invariants"},
        32'({$onehot0(gnt_proc), $onehot0({gnt_snoop, mem_gnt}), (!((|gnt_snoop) || mem_gnt) || busy)}),
        32'h7);
  endtask

  task automatic doReset();
    req_proc  = '0;
    req_snoop = '0;
    mem_req   = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask

  initial begin
    int exp_owner;
    int held;
    req_proc  = '0;
    req_snoop = '0;
    mem_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 0));
    chk("reset timeout flag", 32'(arb_timeout), 0);
    rst_n = 1'b1;

    // req_proc, req_snoop, mem_req | gnt_proc, gnt_snoop, mem_gnt, owner, busy
    vecs[0]  = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0);
    vecs[1]  = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 0, 0);
    vecs[2]  = mk(8'h04, 4'h0, 0, 8'h04, 4'h0, 0, 2, 1);
    vecs[3]  = mk(8'h04, 4'h0, 0, 8'h04, 4'h0, 0, 2, 1);
    vecs[4]  = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 2, 0);
    vecs[5]  = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 2, 0);
    vecs[6]  = mk(8'h03, 4'h0, 0, 8'h01, 4'h0, 0, 0, 1);
    vecs[7]  = mk(8'h01, 4'h3, 1, 8'h01, 4'h2, 0, 0, 1);
    vecs[8]  = mk(8'h01, 4'h3, 1, 8'h01, 4'h2, 0, 0, 1);
    vecs[9]  = mk(8'h01, 4'h1, 1, 8'h01, 4'h0, 1, 0, 1);
    vecs[10] = mk(8'h01, 4'h5, 1, 8'h01, 4'h0, 1, 0, 1);
    vecs[11] = mk(8'h01, 4'h4, 0, 8'h01, 4'h4, 0, 0, 1);
    vecs[12] = mk(8'h00, 4'h4, 0, 8'h00, 4'h0, 0, 0, 0);
    vecs[13] = mk(8'h02, 4'h4, 0, 8'h02, 4'h0, 0, 1, 1);
    vecs[14] = mk(8'h82, 4'h4, 0, 8'h02, 4'h4, 0, 1, 1);
    vecs[15] = mk(8'h80, 4'h0, 0, 8'h00, 4'h0, 0, 1, 0);
    vecs[16] = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 1, 0);
    vecs[17] = mk(8'h00, 4'h0, 0, 8'h00, 4'h0, 0, 1, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      chk($sformatf("vec%0d timeout flag", i), 32'(arb_timeout), 0);
    end

    // Round-robin over all eight requesters, three-cycle tenures, one dead cycle between them.
    doReset();
    req_proc = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      exp_owner = k % 8;
      for (int c = 0; c < 3; c++) begin
        checkOutput($sformatf("rr%0d c%0d", k, c), mk(0, 0, 0, 8'(1 << exp_owner), 4'h0, 0, 3'(exp_owner), 1));
        if (c < 2) step();
      end
      req_proc = 8'hFF & ~8'(1 << exp_owner);
      step();
      checkOutput($sformatf("rr%0d gap", k), mk(0, 0, 0, 8'h00, 4'h0, 0, 3'(exp_owner), 0));
      req_proc = 8'hFF;
      if (k < 8) step();
    end
    req_proc = 8'h00;
    step();

    // Asynchronous reset mid-tenure with a snoop grant outstanding, then pointer restart.
    doReset();
    req_proc  = 8'h10;
    req_snoop = 4'h8;
    step();
    checkOutput("mid proc", mk(0, 0, 0, 8'h10, 4'h0, 0, 4, 1));
    step();
    checkOutput("mid snoop", mk(0, 0, 0, 8'h10, 4'h8, 0, 4, 1));
    rst_n = 1'b0;
    #1;
    checkOutput("async rst", mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 0));
    chk("async rst owner", 32'(owner), 0);
    #1;
    rst_n     = 1'b1;
    req_proc  = 8'h30;
    req_snoop = 4'h0;
    step();
    checkOutput("ptr restart", mk(0, 0, 0, 8'h10, 4'h0, 0, 4, 1));

    doReset();
    req_proc = 8'h01;
    step();
    held = 0;
`ifdef ARB_TIMEOUT_EN
    while (gnt_proc == 8'h01 && held < 40) begin
      held++;
      step();
    end
    chk("timeout tenure length", 32'(held), 16);
    checkOutput("timeout release", mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 0));
    chk("timeout flag set", 32'(arb_timeout), 1);
    step();
    checkOutput("timeout regrant", mk(0, 0, 0, 8'h01, 4'h0, 0, 0, 1));
    repeat (20) step();
    chk("timeout flag sticky", 32'(arb_timeout), 1);
`else
    for (int i = 0; i < 40; i++) begin
      if (gnt_proc == 8'h01) held++;
      step();
    end
    chk("unbounded tenure", 32'(held), 40);
    chk("timeout flag tied low", 32'(arb_timeout), 0);
`endif
    req_proc = 8'h00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
